crc8_framer: RTL and testbench
==============================

CRC8_FRAMER -- requirements
Module: crc8_framer

Interface
REQ-001 The module SHALL have parameter INIT, default 8'h00, giving the CRC seed loaded at reset and at each frame start.
REQ-002 The module SHALL have parameter XOROUT, default 8'h00, XORed onto the final CRC before it is emitted.
REQ-003 The module SHALL have port CLK_I  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port RSTN_I  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port DATA_I  input  8  payload byte.
REQ-006 The module SHALL have port VALID_I  input  1  DATA_I/LAST_I valid.
REQ-007 The module SHALL have port LAST_I  input  1  DATA_I is the final payload byte of the frame.
REQ-008 The module SHALL have port READY_O  output  1  input beat accepted when VALID_I && READY_O.
REQ-009 The module SHALL have port DATA_O  output  8  output byte (payload or CRC).
REQ-010 The module SHALL have port VALID_O  output  1  DATA_O/LAST_O valid.
REQ-011 The module SHALL have port LAST_O  output  1  DATA_O is the appended CRC byte.
REQ-012 The module SHALL have port READY_I  input  1  output beat consumed when VALID_O && READY_I.
REQ-013 The module SHALL have port FRAMES_O  output  16  count of completed frames (CRC beats consumed).

Function
REQ-014 The CRC SHALL be CRC-8, polynomial 0x07 (x^8+x^2+x+1), MSB-first, non-reflected; next = f(crc, byte), with f the same-width combinational update.
REQ-015 The module SHALL implement two states: S_DATA (forward payload) and S_CRC (emit CRC byte).
REQ-016 The output stage SHALL be a single register; "slot free" = !VALID_O || READY_I.
REQ-017 READY_O SHALL equal (state == S_DATA) && slot free, combinationally; it SHALL be 0 in S_CRC.
REQ-018 On an accepted input beat: DATA_O <= DATA_I, LAST_O <= 0, VALID_O <= 1, crc <= f(crc, DATA_I); latency input to output 1 cycle.
REQ-019 An accepted beat with LAST_I=1 SHALL move S_DATA -> S_CRC.
REQ-020 In S_CRC with slot free: DATA_O <= crc ^ XOROUT, LAST_O <= 1, VALID_O <= 1, crc <= INIT, state -> S_DATA.
REQ-021 Slot free with no new beat SHALL clear VALID_O; DATA_O/LAST_O SHALL be held stable while VALID_O && !READY_I.
REQ-022 Sustained throughput with READY_I=1 SHALL be N+1 cycles per N-byte frame; back-to-back frames need no idle cycle beyond the CRC beat.
REQ-023 A frame SHALL contain at least one payload byte; a 1-byte frame (VALID_I && LAST_I on first beat) is legal.
REQ-024 FRAMES_O SHALL increment when the CRC beat is consumed (VALID_O && READY_I && LAST_O) and wrap 16'hFFFF -> 16'h0000.
REQ-025 VALID_I, DATA_I and LAST_I SHALL be ignored when READY_O=0; no combinational path from VALID_I to READY_O.

Reset
REQ-026 RSTN_I low SHALL asynchronously force state=S_DATA, crc=INIT, VALID_O=0, LAST_O=0, DATA_O=8'h00, FRAMES_O=0.
REQ-027 Reset mid-frame or while the CRC beat is pending SHALL discard the partial frame with no CRC emitted; deassertion is treated as synchronous to CLK_I by the instantiating level.

Structure
REQ-028 Package crc8_pkg SHALL hold CRC_W=8, POLY=8'h07, the state enum typedef, and the check constant 8'hF4.
REQ-029 The CRC update SHALL be a single instance of the existing combinational sub-module calc_crc (CRC_I=crc register, DATA_I=input byte); no other sub-module.

Verification
REQ-030 Bytes 0x31..0x39 ("123456789"), LAST on 0x39, READY_I=1 -> 9 payload beats then DATA_O=0xF4, LAST_O=1; FRAMES_O=1.
REQ-031 1-byte frame 0x01 -> output 0x01 then 0x07 (LAST_O=1); second frame 0x00 -> 0x00 then 0x00.
REQ-032 READY_I toggled randomly over REQ-030 frame -> identical byte sequence, DATA_O stable while stalled, no beat lost or duplicated.
REQ-033 Two back-to-back frames, VALID_I=1 throughout -> READY_O=0 exactly one cycle per frame (CRC beat); second CRC independent of first (seed reset).
REQ-034 RSTN_I pulsed after 4 bytes of a frame -> VALID_O=0 immediately, no CRC beat; next "123456789" frame yields 0xF4.
REQ-035 Force FRAMES_O to 16'hFFFF via 65535 one-byte frames (or preload in sim) -> next completed frame reads 16'h0000.

Source files
------------

// File: rtl/crc8_pkg.sv
// crc8_pkg -- shared definitions for the CRC-8 framer.
//   CRC_W     : CRC register width
//   POLY      : generator polynomial x^8+x^2+x+1, MSB-first, non-reflected
//   CRC_CHECK : CRC-8 of the ASCII string "123456789" with a zero seed
//   state_t   : framer FSM states
//   crc8_update() : one-byte combinational CRC update
package crc8_pkg;

  localparam int              CRC_W     = 8;
  localparam logic [CRC_W-1:0] POLY      = 8'h07;
  localparam logic [CRC_W-1:0] CRC_CHECK = 8'hF4;

  typedef enum logic {
    S_DATA = 1'b0,
    S_CRC  = 1'b1
  } state_t;

  // Byte-at-a-time update: fold the whole byte in first, then shift eight
  // times, reducing by POLY whenever a one falls off the top.
  function automatic logic [CRC_W-1:0] crc8_update(input logic [CRC_W-1:0] crc,
                                                    input logic [7:0]       data);
    logic [CRC_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[CRC_W-1]) begin
        c = {c[CRC_W-2:0], 1'b0} ^ POLY;
      end else begin
        c = {c[CRC_W-2:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/calc_crc.sv
// calc_crc -- purely combinational CRC-8 (poly 0x07) update of one byte.
//   CRC_I  [7:0] : current CRC value
//   DATA_I [7:0] : byte to fold in
//   CRC_O  [7:0] : updated CRC
module calc_crc
  import crc8_pkg::*;
(
  input  logic [CRC_W-1:0] CRC_I,
  input  logic [7:0]       DATA_I,
  output logic [CRC_W-1:0] CRC_O
);

  assign CRC_O = crc8_update(CRC_I, DATA_I);

endmodule

// File: rtl/crc8_framer.sv
// crc8_framer -- streams payload bytes through a one-register output stage
// and appends a CRC-8 byte after the beat marked LAST_I.
//   CLK_I     : clock, rising edge
//   RSTN_I    : asynchronous active-low reset
//   DATA_I    : payload byte        VALID_I : input beat valid
//   LAST_I    : final payload byte   READY_O : input beat accepted
//   DATA_O    : payload or CRC byte  VALID_O : output beat valid
//   LAST_O    : DATA_O is the CRC    READY_I : output beat consumed
//   FRAMES_O  : count of consumed CRC beats (wraps)
module crc8_framer
  import crc8_pkg::*;
#(
  parameter logic [7:0] INIT   = 8'h00,
  parameter logic [7:0] XOROUT = 8'h00
)(
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic [7:0]  DATA_I,
  input  logic        VALID_I,
  input  logic        LAST_I,
  output logic        READY_O,
  output logic [7:0]  DATA_O,
  output logic        VALID_O,
  output logic        LAST_O,
  input  logic        READY_I,
  output logic [15:0] FRAMES_O
);

  state_t           state_r;
  logic [CRC_W-1:0] crc_r;
  logic [CRC_W-1:0] crc_next_s;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             last_r;
  logic [15:0]      frames_r;
  logic             slot_free_s;

  calc_crc u_calc_crc (
    .CRC_I  (crc_r),
    .DATA_I (DATA_I),
    .CRC_O  (crc_next_s)
  );

  // The output register may be loaded when it is empty or being drained.
  // READY_O depends only on registered state and READY_I, never on VALID_I.
  assign slot_free_s = !valid_r || READY_I;
  assign READY_O     = (state_r == S_DATA) && slot_free_s;

  assign DATA_O   = data_r;
  assign VALID_O  = valid_r;
  assign LAST_O   = last_r;
  assign FRAMES_O = frames_r;

  // Framer FSM, CRC accumulator, output stage and frame counter.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_r  <= S_DATA;
      crc_r    <= INIT;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      frames_r <= 16'h0000;
    end else begin
      // Count a frame only once its CRC beat has actually left.
      if (valid_r && READY_I && last_r) begin
        frames_r <= frames_r + 16'd1;
      end else begin
        frames_r <= frames_r;
      end

      // While stalled (VALID_O && !READY_I) nothing below fires, so the
      // output beat is held stable.
      if (slot_free_s) begin
        case (state_r)
          S_DATA: begin
            if (VALID_I) begin
              data_r  <= DATA_I;
              last_r  <= 1'b0;
              valid_r <= 1'b1;
              crc_r   <= crc_next_s;
              if (LAST_I) begin
                state_r <= S_CRC;
              end else begin
                state_r <= S_DATA;
              end
            end else begin
              valid_r <= 1'b0;
            end
          end
          S_CRC: begin
            // Reseed here so a back-to-back frame starts clean next cycle.
            data_r  <= crc_r ^ XOROUT;
            last_r  <= 1'b1;
            valid_r <= 1'b1;
            crc_r   <= INIT;
            state_r <= S_DATA;
          end
          default: begin
            state_r <= S_DATA;
            crc_r   <= INIT;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_crc8_framer.sv
// tb_crc8_framer -- scoreboard bench for crc8_framer. Expected beats are
// queued when an input beat is accepted and compared as output beats drain.
module tb_crc8_framer;

  localparam logic [7:0] INIT   = 8'h00;
  localparam logic [7:0] XOROUT = 8'h00;
  localparam logic [7:0] POLY   = 8'h07;

  logic        clk;
  logic        rstn;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  logic [15:0] frames_o;

  crc8_framer #(.INIT(INIT), .XOROUT(XOROUT)) dut (
    .CLK_I    (clk),
    .RSTN_I   (rstn),
    .DATA_I   (data_i),
    .VALID_I  (valid_i),
    .LAST_I   (last_i),
    .READY_O  (ready_o),
    .DATA_O   (data_o),
    .VALID_O  (valid_o),
    .LAST_O   (last_o),
    .READY_I  (ready_i),
    .FRAMES_O (frames_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [8:0]  stim_q[$];   // {last, data} to drive
  logic [8:0]  sb_q[$];     // {last, data} expected on the output
  logic [7:0]  model_crc;
  logic [15:0] frames_exp;
  int          cyc;
  int          stalls;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bit-serial reference CRC (LFSR form, independent of the byte-wise RTL).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return r;
  endfunction

  task automatic push_123456789();
    for (int i = 0; i < 9; i++) begin
      stim_q.push_back({(i == 8), 8'h31 + 8'(i)});
    end
  endtask

  // Drive stim_q, scoreboard the output. rnd randomises READY_I; drain waits
  // for the scoreboard to empty as well as the stimulus.
  task automatic run(input bit rnd, input bit drain, input int budget,
                     output int cycles, output int not_ready);
    logic       held;
    logic [7:0] held_data;
    logic [8:0] exp;
    held      = 1'b0;
    held_data = 8'h00;
    cycles    = 0;
    not_ready = 0;
    while (((stim_q.size() != 0) || (drain && sb_q.size() != 0)) && cycles < budget) begin
      @(negedge clk);
      cycles++;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stim_q.size() != 0) begin
        valid_i = 1'b1;
        data_i  = stim_q[0][7:0];
        last_i  = stim_q[0][8];
      end else begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        last_i  = 1'($urandom_range(0, 1));
      end
      #1;
      if (held) check("stall_hold", {8'h00, data_o}, {8'h00, held_data});
      held      = valid_o && !ready_i;
      held_data = data_o;
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          check("extra_beat", {8'h00, data_o}, 16'hFFFF);
        end else begin
          exp = sb_q.pop_front();
          check("data", {8'h00, data_o}, {8'h00, exp[7:0]});
          check("last", {15'h0, last_o}, {15'h0, exp[8]});
          if (exp[8]) frames_exp++;
        end
      end
      if (valid_i && ready_o) begin
        sb_q.push_back({1'b0, data_i});
        model_crc = ref_crc(model_crc, data_i);
        if (last_i) begin
          sb_q.push_back({1'b1, model_crc ^ XOROUT});
          model_crc = INIT;
        end
        void'(stim_q.pop_front());
      end else if (valid_i) begin
        not_ready++;
      end
    end
    if ((stim_q.size() != 0) || (drain && sb_q.size() != 0)) begin
      check("timeout", 16'h0001, 16'h0000);
      stim_q.delete();
    end
  endtask

  // One idle cycle so the last consumption lands, then check counter/idle.
  task automatic settle(input string tag);
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "_frames"}, frames_o, frames_exp);
    check({tag, "_idle"}, {15'h0, valid_o}, 16'h0000);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_crc  = INIT;
    frames_exp = 16'h0000;
    rstn       = 1'b0;
    data_i     = 8'h00;
    valid_i    = 1'b0;
    last_i     = 1'b0;
    ready_i    = 1'b0;

    // Reset state.
    #12;
    check("rst_valid", {15'h0, valid_o}, 16'h0000);
    check("rst_last", {15'h0, last_o}, 16'h0000);
    check("rst_data", {8'h00, data_o}, 16'h0000);
    check("rst_frames", frames_o, 16'h0000);
    check("rst_ready", {15'h0, ready_o}, 16'h0001);
    @(negedge clk);
    rstn = 1'b1;

    // "123456789" with READY_I high, CRC must be the 0xF4 check value.
    push_123456789();
    check("sb_check_value", {8'h00, sb_q.size() == 0 ? 8'hF4 : 8'h00}, 16'h00F4);
    run(1'b0, 1'b1, 100, cyc, stalls);
    settle("check_frame");
    check("check_frames_one", frames_o, 16'h0001);

    // One-byte frames 0x01 -> 0x07 and 0x00 -> 0x00.
    stim_q.push_back({1'b1, 8'h01});
    stim_q.push_back({1'b1, 8'h00});
    run(1'b0, 1'b1, 100, cyc, stalls);
    settle("one_byte");

    // Random backpressure over the check frame, several times.
    for (int k = 0; k < 4; k++) begin
      push_123456789();
      run(1'b1, 1'b1, 400, cyc, stalls);
    end
    settle("stall");

    // Back-to-back 3-byte frames with VALID_I held high: one non-ready
    // cycle between them, full output rate (8 beats over 9 cycles).
    stim_q.push_back({1'b0, 8'hA5});
    stim_q.push_back({1'b0, 8'h5A});
    stim_q.push_back({1'b1, 8'hC3});
    stim_q.push_back({1'b0, 8'hA5});
    stim_q.push_back({1'b0, 8'h5A});
    stim_q.push_back({1'b1, 8'hC3});
    run(1'b0, 1'b1, 100, cyc, stalls);
    check("b2b_not_ready", 16'(stalls), 16'd1);
    check("b2b_cycles", 16'(cyc), 16'd9);
    settle("b2b");

    // Reset after 4 payload bytes: output drops, no CRC appears.
    for (int i = 0; i < 4; i++) stim_q.push_back({1'b0, 8'h31 + 8'(i)});
    run(1'b0, 1'b0, 100, cyc, stalls);
    @(negedge clk);
    valid_i = 1'b0;
    rstn    = 1'b0;
    #1;
    check("midrst_valid", {15'h0, valid_o}, 16'h0000);
    check("midrst_frames", frames_o, 16'h0000);
    sb_q.delete();
    model_crc  = INIT;
    frames_exp = 16'h0000;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_crc", {15'h0, valid_o}, 16'h0000);
    end
    push_123456789();
    run(1'b0, 1'b1, 100, cyc, stalls);
    settle("after_rst");

    // Counter wrap: preload FFFF, one more frame brings it to 0000.
    @(negedge clk);
    force dut.frames_r = 16'hFFFF;
    #1;
    release dut.frames_r;
    #1;
    check("wrap_preload", frames_o, 16'hFFFF);
    frames_exp = 16'hFFFF;
    stim_q.push_back({1'b1, 8'h42});
    run(1'b0, 1'b1, 100, cyc, stalls);
    settle("wrap");
    check("wrap_zero", frames_o, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
